// File: rtl/seq_sub_pkg.sv
// Shared definitions for the multi-cycle subtractor.
//   - Default operand and chunk widths.
//   - FSM state type.
//   - idx_width(): width of the chunk index, clog2(NCHUNK) with a minimum of 1.
// Optional feature macro used by the top: SEQ_SUB_FLAGS_EN.
package seq_sub_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_CHUNK_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK_W-bit add slice: {co, s} = x + y + ci.
// The top feeds it a and ~b so that, with the carry chain, it subtracts.
// Ports:
//   x, y  [W-1:0]  slice operands
//   ci             carry-in
//   s     [W-1:0]  slice sum
//   co             carry-out
// Optional feature macro: none (SEQ_SUB_FLAGS_EN lives in the top).
module sub_chunk #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] sum;

    assign sum      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    assign {co, s}  = sum;

endmodule

// File: rtl/seq_sub_32bit.sv
// Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), CHUNK_W bits per clock,
// computed as a + ~b + ~bin through a carry register. Valid/ready on both sides.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready high only in idle)
//   a, b, bin            minuend, subtrahend, borrow-in
//   out_valid, out_ready result handshake
//   diff, bout           difference and borrow-out (1 iff a < b + bin, unsigned)
//   zero, neg, ovf       result flags, present only with SEQ_SUB_FLAGS_EN defined
// Optional feature macro: SEQ_SUB_FLAGS_EN.
module seq_sub_32bit
    import seq_sub_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned CHUNK_W = DEF_CHUNK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SEQ_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK_W;
    localparam int unsigned IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_e             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   nb_q;       // subtrahend stored already inverted
    logic               carry;
    logic [IDX_W-1:0]   idx;

    logic [CHUNK_W-1:0] x_sl;
    logic [CHUNK_W-1:0] y_sl;
    logic [CHUNK_W-1:0] s_sl;
    logic               co;
    logic [WIDTH-1:0]   diff_next;

    always_comb begin
        x_sl = a_q[int'(idx)*CHUNK_W +: CHUNK_W];
        y_sl = nb_q[int'(idx)*CHUNK_W +: CHUNK_W];
    end

    sub_chunk #(
        .W (CHUNK_W)
    ) u_sub_chunk (
        .x  (x_sl),
        .y  (y_sl),
        .ci (carry),
        .s  (s_sl),
        .co (co)
    );

    // Full result as it will look once the current slice is written.
    always_comb begin
        diff_next = diff;
        diff_next[int'(idx)*CHUNK_W +: CHUNK_W] = s_sl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            nb_q      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
`ifdef SEQ_SUB_FLAGS_EN
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a;
                        nb_q     <= ~b;
                        carry    <= ~bin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= StBusy;
                    end
                end
                StBusy: begin
                    diff  <= diff_next;
                    carry <= co;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        state     <= StDone;
                        out_valid <= 1'b1;
                        // No final carry out of a + ~b + ~bin means a borrow occurred.
                        bout      <= ~co;
`ifdef SEQ_SUB_FLAGS_EN
                        zero      <= (diff_next == '0);
                        neg       <= diff_next[WIDTH-1];
                        // nb_q holds ~b, so equal MSBs here mean a and b differ in sign.
                        ovf       <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                                     (diff_next[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sub_32bit.sv
// Self-checking bench for seq_sub_32bit: directed cases with literal expectations plus
// 1000 random operations with random stalls, checked against an arithmetic model.
// Flag checks are compiled in only when SEQ_SUB_FLAGS_EN is defined.
module tb_seq_sub_32bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        bout;
`ifdef SEQ_SUB_FLAGS_EN
    logic        zero;
    logic        neg;
    logic        ovf;
`endif

    seq_sub_32bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SEQ_SUB_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic [2:0]  fl;     // {zero, neg, ovf}
        int          acc_cyc;
    } exp_t;

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic bi, input int cyc_now);
        exp_t e;
        logic [32:0] rhs;
        e.d   = av - bv - {31'd0, bi};
        rhs   = {1'b0, bv} + {32'd0, bi};
        e.bo  = ({1'b0, av} < rhs);
        e.fl  = {e.d == 32'd0, e.d[31], (av[31] != bv[31]) && (e.d[31] != av[31])};
        e.acc_cyc = cyc_now;
        return e;
    endfunction

    exp_t        q[$];
    int          cyc = 0;
    int          n_results = 0;
    logic [31:0] last_diff = '0;
    logic        last_bout = 1'b0;
    logic [2:0]  last_flags = '0;
    logic        prev_ov = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] held_diff = '0;
    logic        held_bout = 1'b0;
    bit          rand_ready = 1'b0;
    bit          force_ready = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end

    // Compare process: handshakes are sampled mid-cycle, before the edge that acts on them.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_ov    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_diff", {32'd0, diff}, {32'd0, held_diff});
                chk("hold_bout", {63'd0, bout}, {63'd0, held_bout});
            end
            if (out_valid) chk("in_ready_while_valid", {63'd0, in_ready}, 64'd0);
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
                else chk("latency", 64'(cyc - q[0].acc_cyc), 64'd5);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("diff", {32'd0, diff}, {32'd0, e.d});
                    chk("bout", {63'd0, bout}, {63'd0, e.bo});
`ifdef SEQ_SUB_FLAGS_EN
                    chk("flags", {61'd0, zero, neg, ovf}, {61'd0, e.fl});
                    last_flags = {zero, neg, ovf};
`endif
                end
                last_diff = diff;
                last_bout = bout;
                n_results++;
            end
            if (in_valid && in_ready) q.push_back(model(a, b, bin, cyc));
            prev_ov    = out_valid;
            prev_stall = out_valid && !out_ready;
            held_diff  = diff;
            held_bout  = bout;
        end
    end

    // ---------------- driver helpers (called at posedge + #1) ----------------
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic bi);
        int  n = 0;
        bit  acc = 1'b0;
        a = av;
        b = bv;
        bin = bi;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int n0);
        int n = 0;
        while (n_results <= n0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("result_timeout", {63'd0, n_results > n0}, 64'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic bi, input logic [31:0] ed, input logic eb);
        int n0;
        n0 = n_results;
        send(av, bv, bi);
        wait_result(n0);
        chk({name, "_diff"}, {32'd0, last_diff}, {32'd0, ed});
        chk({name, "_bout"}, {63'd0, last_bout}, {63'd0, eb});
    endtask

`ifdef SEQ_SUB_FLAGS_EN
    task automatic chk_flags(input string name, input logic [2:0] ef);
        chk({name, "_flags"}, {61'd0, last_flags}, {61'd0, ef});
    endtask
`endif

    task automatic check_idle(input string name);
        @(negedge clk);
        chk({name, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({name, "_diff"}, {32'd0, diff}, 64'd0);
        chk({name, "_bout"}, {63'd0, bout}, 64'd0);
        chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        int base;
        int n;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        run_op("a5_b3", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0);
`ifdef SEQ_SUB_FLAGS_EN
        chk_flags("a5_b3", 3'b000);
`endif
        run_op("a0_b1", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1);
`ifdef SEQ_SUB_FLAGS_EN
        chk_flags("a0_b1", 3'b010);
`endif
        run_op("min_m1", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0);
`ifdef SEQ_SUB_FLAGS_EN
        chk_flags("min_m1", 3'b001);
`endif
        run_op("a10_b3_bin", 32'd10, 32'd3, 1'b1, 32'd6, 1'b0);
        run_op("a_eq_b", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'd0, 1'b0);
`ifdef SEQ_SUB_FLAGS_EN
        chk_flags("a_eq_b", 3'b100);
`endif
        run_op("ripple01", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0);
        run_op("zero_bin", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);

        // Backpressure: result held for 5 cycles while a new operand waits.
        force_ready = 1'b0;
        @(posedge clk);
        #1;
        n0 = n_results;
        send(32'h0000_1000, 32'h0000_0001, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_valid_seen", {63'd0, out_valid}, 64'd1);
        a = 32'h20;
        b = 32'h8;
        bin = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_no_result", 64'(n_results), 64'(n0));
        chk("bp_held_diff", {32'd0, diff}, 64'h0FFF);
        force_ready = 1'b1;
        wait_result(n0);
        chk("bp_diff", {32'd0, last_diff}, 64'h0FFF);
        n0 = n_results;
        send(32'h20, 32'h8, 1'b1);
        wait_result(n0);
        chk("bp_next_diff", {32'd0, last_diff}, 64'h17);
        chk("bp_next_bout", {63'd0, last_bout}, 64'd0);

        // Reset on the second busy cycle abandons the operation.
        send(32'd1, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("mid_reset");
        run_op("after_reset", 32'd7, 32'd9, 1'b0, 32'hFFFF_FFFE, 1'b1);

        // Random operations with random idle gaps and output stalls.
        rand_ready = 1'b1;
        base = n_results;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            if ($urandom_range(0, 15) == 0) ra = 32'd0;
            send(ra, rb, 1'($urandom_range(0, 1)));
        end
        n = 0;
        while ((n_results - base) < 1000 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        rand_ready = 1'b0;
        chk("random_count", 64'(n_results - base), 64'd1000);
        chk("queue_drained", 64'(q.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
